// File: rtl/fft_merge_pkg.sv
// Shared types and twiddle generation for the radix-4 DIT merge datapath.
// Elaboration-time only: nothing here is clocked.
// Twiddles are computed in Q30 integer arithmetic, then rounded to the requested width.
package fft_merge_pkg;

  localparam int N_LOG2_DEF = 6;
  localparam int N_QTR      = (1 << N_LOG2_DEF) / 4;
  localparam int TWID_MAX_W = 30;

  // 2*pi in Q30
  localparam longint PI2_Q30 = 64'sd6746518852;

  typedef enum logic {IDLE, RUN} seq_state_e;

  typedef struct packed {
    logic signed [TWID_MAX_W-1:0] r;
    logic signed [TWID_MAX_W-1:0] i;
  } twid_t;

  // Round a non-negative Q30 magnitude to Q1.(w-1), saturating +1.0 to the largest code
  function automatic longint q30_round(input longint v, input int twid_width);
    longint lim;
    longint res;
    lim = (longint'(1) << (twid_width - 1)) - 1;
    res = (v + (longint'(1) << (30 - twid_width))) >>> (31 - twid_width);
    if (res > lim) res = lim;
    if (res < 0) res = 0;
    return res;
  endfunction

  // Entry idx of the N-point table {cos(2*pi*idx/N), -sin(2*pi*idx/N)}.
  // Sine/cosine come from a Taylor series over the first quadrant only;
  // the other quadrants are mirrored so every entry is sign-symmetric.
  function automatic twid_t gen_twiddle(input int n_log2, input int twid_width, input int idx);
    twid_t  res;
    int     qtr;
    int     quad;
    int     rem;
    longint x;
    longint x2;
    longint s;
    longint c;
    longint ts;
    longint tc;
    longint sq;
    longint cq;
    qtr  = 1 << (n_log2 - 2);
    quad = idx / qtr;
    rem  = idx % qtr;
    x    = (PI2_Q30 * rem + (longint'(1) << (n_log2 - 1))) >>> n_log2;
    x2   = (x * x) >>> 30;
    s    = x;
    c    = longint'(1) << 30;
    ts   = s;
    tc   = c;
    for (int j = 1; j <= 10; j++) begin
      ts = -(((ts * x2) >>> 30) / longint'(2 * j * (2 * j + 1)));
      tc = -(((tc * x2) >>> 30) / longint'((2 * j - 1) * (2 * j)));
      s  = s + ts;
      c  = c + tc;
    end
    sq = q30_round(s, twid_width);
    cq = q30_round(c, twid_width);
    case (quad)
      0:       begin res.r = TWID_MAX_W'(cq);  res.i = TWID_MAX_W'(-sq); end
      1:       begin res.r = TWID_MAX_W'(-sq); res.i = TWID_MAX_W'(-cq); end
      2:       begin res.r = TWID_MAX_W'(-cq); res.i = TWID_MAX_W'(sq);  end
      default: begin res.r = TWID_MAX_W'(sq);  res.i = TWID_MAX_W'(cq);  end
    endcase
    return res;
  endfunction

endpackage

// File: rtl/fft_twiddle_rom.sv
// Twiddle ROM: N entries of {cos, -sin} built at elaboration.
// Latency 1 cycle; output register holds its value while rd_en_i is low.
// No backpressure.
module fft_twiddle_rom
  import fft_merge_pkg::*;
#(
  parameter int N_LOG2     = 6,
  parameter int TWID_WIDTH = 16
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         rd_en_i,
  input  logic [N_LOG2-1:0]            addr_i,
  output logic signed [TWID_WIDTH-1:0] b_r_o,
  output logic signed [TWID_WIDTH-1:0] b_i_o
);

  localparam int N = 1 << N_LOG2;

  logic [2*TWID_WIDTH-1:0] rom_w [N];
  logic [2*TWID_WIDTH-1:0] data_q;

  for (genvar g = 0; g < N; g++) begin : g_rom
    localparam twid_t ENT = gen_twiddle(N_LOG2, TWID_WIDTH, g);
    assign rom_w[g] = {ENT.r[TWID_WIDTH-1:0], ENT.i[TWID_WIDTH-1:0]};
  end

  // registered read, updated only for valid addresses so bubbles hold the last twiddle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       data_q <= '0;
    else if (rd_en_i) data_q <= rom_w[addr_i];
  end

  assign b_r_o = data_q[2*TWID_WIDTH-1:TWID_WIDTH];
  assign b_i_o = data_q[TWID_WIDTH-1:0];

endmodule

// File: rtl/fft_twiddle_seq.sv
// Frame sequencer pairing each branch-major sample with twiddle W_N^(m*k).
// Latency 2 cycles for data, twiddle, flags and frame_err.
// No backpressure: every valid sample is accepted; invalid cycles become bubbles.
module fft_twiddle_seq
  import fft_merge_pkg::*;
#(
  parameter int DATA_WIDTH = 21,
  parameter int TWID_WIDTH = 16,
  parameter int N_LOG2     = 6
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_valid,
  input  logic                         in_sop,
  input  logic signed [DATA_WIDTH-1:0] in_r,
  input  logic signed [DATA_WIDTH-1:0] in_i,
  output logic                         out_valid,
  output logic                         out_sop,
  output logic                         out_eop,
  output logic signed [DATA_WIDTH-1:0] a_r,
  output logic signed [DATA_WIDTH-1:0] a_i,
  output logic signed [TWID_WIDTH-1:0] b_r,
  output logic signed [TWID_WIDTH-1:0] b_i,
  output logic                         frame_err
);

  localparam logic [N_LOG2-3:0] K_MAX = '1;

  seq_state_e state_q, state_d;
  logic [N_LOG2-3:0] k_q, k_d, cur_k;
  logic [1:0]        m_q, m_d, cur_m;
  logic [N_LOG2-1:0] e_q, e_d, cur_e;
  logic              acc, s0_sop, s0_eop, s0_err;

  logic                         s1_vld_q, s1_sop_q, s1_eop_q, s1_err_q;
  logic signed [DATA_WIDTH-1:0] s1_r_q, s1_i_q;
  logic [N_LOG2-1:0]            s1_e_q;

  logic                         s2_vld_q, s2_sop_q, s2_eop_q, s2_err_q;
  logic signed [DATA_WIDTH-1:0] s2_r_q, s2_i_q;

  // state and counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      k_q     <= '0;
      m_q     <= '0;
      e_q     <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      m_q     <= m_d;
      e_q     <= e_d;
    end
  end

  // acceptance, framing checks and counter advance; an sop always forces n=0
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    m_d     = m_q;
    e_d     = e_q;
    acc     = 1'b0;
    s0_sop  = 1'b0;
    s0_eop  = 1'b0;
    s0_err  = 1'b0;
    cur_k   = k_q;
    cur_m   = m_q;
    cur_e   = e_q;
    if (in_valid) begin
      if (in_sop) begin
        acc    = 1'b1;
        s0_sop = 1'b1;
        s0_err = (state_q == RUN);
        cur_k  = '0;
        cur_m  = '0;
        cur_e  = '0;
      end else if (state_q == RUN) begin
        acc = 1'b1;
      end else begin
        s0_err = 1'b1;
      end
    end
    if (acc) begin
      s0_eop = (cur_m == 2'd3) && (cur_k == K_MAX);
      if (cur_k == K_MAX) begin
        k_d     = '0;
        m_d     = cur_m + 2'd1;
        e_d     = '0;
        state_d = (cur_m == 2'd3) ? IDLE : RUN;
      end else begin
        k_d     = cur_k + (N_LOG2-2)'(1);
        m_d     = cur_m;
        e_d     = cur_e + N_LOG2'(cur_m);
        state_d = RUN;
      end
    end
  end

  // stage 1: ROM address with data and flags; data holds across bubbles
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_vld_q <= 1'b0;
      s1_sop_q <= 1'b0;
      s1_eop_q <= 1'b0;
      s1_err_q <= 1'b0;
      s1_r_q   <= '0;
      s1_i_q   <= '0;
      s1_e_q   <= '0;
    end else begin
      s1_vld_q <= acc;
      s1_sop_q <= s0_sop;
      s1_eop_q <= s0_eop;
      s1_err_q <= s0_err;
      if (acc) begin
        s1_r_q <= in_r;
        s1_i_q <= in_i;
        s1_e_q <= cur_e;
      end
    end
  end

  // stage 2: delayed data and flags, aligned with the ROM read
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_vld_q <= 1'b0;
      s2_sop_q <= 1'b0;
      s2_eop_q <= 1'b0;
      s2_err_q <= 1'b0;
      s2_r_q   <= '0;
      s2_i_q   <= '0;
    end else begin
      s2_vld_q <= s1_vld_q;
      s2_sop_q <= s1_sop_q;
      s2_eop_q <= s1_eop_q;
      s2_err_q <= s1_err_q;
      if (s1_vld_q) begin
        s2_r_q <= s1_r_q;
        s2_i_q <= s1_i_q;
      end
    end
  end

  fft_twiddle_rom #(
    .N_LOG2     (N_LOG2),
    .TWID_WIDTH (TWID_WIDTH)
  ) u_rom (
    .clk     (clk),
    .rst_n   (rst_n),
    .rd_en_i (s1_vld_q),
    .addr_i  (s1_e_q),
    .b_r_o   (b_r),
    .b_i_o   (b_i)
  );

  assign out_valid = s2_vld_q;
  assign out_sop   = s2_sop_q;
  assign out_eop   = s2_eop_q;
  assign frame_err = s2_err_q;
  assign a_r       = s2_r_q;
  assign a_i       = s2_i_q;

endmodule

// File: tb/tb_fft_twiddle_seq.sv
module tb_fft_twiddle_seq;

  localparam int  DW   = 21;
  localparam int  TW   = 16;
  localparam int  NL   = 4;
  localparam int  NN   = 1 << NL;
  localparam int  QTR  = NN / 4;
  localparam real PI   = 3.14159265358979;

  typedef struct packed {
    logic                 vld;
    logic                 sop;
    logic                 eop;
    logic                 err;
    logic signed [DW-1:0] ar;
    logic signed [DW-1:0] ai;
    logic signed [TW-1:0] br;
    logic signed [TW-1:0] bi;
  } exp_t;

  typedef struct {
    int n;
    int e;
    int br;
    int bi;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n;
  logic in_valid, in_sop;
  logic signed [DW-1:0] in_r, in_i;
  logic out_valid, out_sop, out_eop, frame_err;
  logic signed [DW-1:0] a_r, a_i;
  logic signed [TW-1:0] b_r, b_i;

  fft_twiddle_seq #(.DATA_WIDTH(DW), .TWID_WIDTH(TW), .N_LOG2(NL)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_sop(in_sop),
    .in_r(in_r), .in_i(in_i), .out_valid(out_valid), .out_sop(out_sop),
    .out_eop(out_eop), .a_r(a_r), .a_i(a_i), .b_r(b_r), .b_i(b_i),
    .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  exp_t  sb[$];
  int    n_vec = 0;
  int    n_bad = 0;
  int    errs_seen = 0;
  string tag = "init";

  // reference model state
  bit                   m_run;
  int                   m_n;
  logic signed [DW-1:0] m_ar, m_ai;
  logic signed [TW-1:0] m_br, m_bi;

  function automatic logic signed [TW-1:0] q15(input real x);
    real y;
    int  v;
    y = x * 32768.0;
    if (y >= 0.0) v = $rtoi(y + 0.5);
    else          v = -$rtoi(-y + 0.5);
    if (v > 32767)  v = 32767;
    if (v < -32767) v = -32767;
    return TW'(v);
  endfunction

  task automatic model_reset();
    m_run = 1'b0; m_n = 0;
    m_ar = '0; m_ai = '0; m_br = '0; m_bi = '0;
  endtask

  task automatic model(input bit v, input bit s, input int r, input int i, output exp_t e);
    bit acc;
    int n, ex;
    acc = 1'b0;
    e   = '0;
    if (v) begin
      if (s) begin
        e.err = m_run; m_run = 1'b1; m_n = 0; acc = 1'b1;
      end else if (m_run) acc = 1'b1;
      else e.err = 1'b1;
    end
    if (acc) begin
      n    = m_n;
      ex   = (n / QTR) * (n % QTR);
      m_ar = DW'(r);
      m_ai = DW'(i);
      m_br = q15($cos(2.0 * PI * ex / NN));
      m_bi = q15(-$sin(2.0 * PI * ex / NN));
      e.vld = 1'b1;
      e.sop = (n == 0);
      e.eop = (n == NN - 1);
      m_n++;
      if (m_n == NN) begin m_run = 1'b0; m_n = 0; end
    end
    e.ar = m_ar; e.ai = m_ai; e.br = m_br; e.bi = m_bi;
  endtask

  task automatic compare(input exp_t e);
    exp_t act;
    act = {out_valid, out_sop, out_eop, frame_err, a_r, a_i, b_r, b_i};
    n_vec++;
    if (frame_err) errs_seen++;
    if (act !== e) begin
      n_bad++;
      $display("FAIL %s #%0d: got v/s/e/err=%b%b%b%b a=(%0d,%0d) b=(%0d,%0d), required v/s/e/err=%b%b%b%b a=(%0d,%0d) b=(%0d,%0d)",
               tag, n_vec, act.vld, act.sop, act.eop, act.err, act.ar, act.ai, act.br, act.bi,
               e.vld, e.sop, e.eop, e.err, e.ar, e.ai, e.br, e.bi);
    end
  endtask

  task automatic chk_zero(input string nm);
    n_vec++;
    if ({out_valid, out_sop, out_eop, frame_err, a_r, a_i, b_r, b_i} !== '0) begin
      n_bad++;
      $display("FAIL %s: outputs=%h required all zero", nm,
               {out_valid, out_sop, out_eop, frame_err, a_r, a_i, b_r, b_i});
    end
  endtask

  task automatic chk_int(input string nm, input int act, input int req);
    n_vec++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s: got %0d required %0d", nm, act, req);
    end
  endtask

  // one cycle: check the output due now, drive new inputs, queue their expectation
  task automatic step(input bit v, input bit s, input int r, input int i,
                      input bit ovr, input exp_t ovr_rec);
    exp_t e;
    @(negedge clk);
    if (sb.size() == 2) compare(sb.pop_front());
    in_valid = v;
    in_sop   = s;
    in_r     = DW'(r);
    in_i     = DW'(i);
    model(v, s, r, i, e);
    if (ovr) e = ovr_rec;
    sb.push_back(e);
  endtask

  task automatic idle(input int c);
    repeat (c) step(1'b0, 1'b0, 7777, -7777, 1'b0, '0);
  endtask

  task automatic sample(input bit s, input int r, input int i);
    step(1'b1, s, r, i, 1'b0, '0);
  endtask

  // drop reset between clock edges and check outputs clear without an edge
  task automatic do_reset(input string nm);
    #2 rst_n = 1'b0;
    #1 chk_zero(nm);
    sb.delete();
    model_reset();
    in_valid = 1'b0;
    in_sop   = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  vec_t tbl[NN];

  initial begin
    exp_t ov;
    int   err0;
    int   ev[NN];
    int   vr[10];
    int   vi[10];
    ev = '{0,0,0,0, 0,1,2,3, 0,2,4,6, 0,3,6,9};
    vr = '{32767, 30274, 23170, 12540, 0, 0, 0, 0, 0, 0};
    vi = '{0, -12540, -23170, -30274, -32767, 0, 0, 0, 0, 0};
    vr[6] = -23170; vi[6] = -23170;
    vr[9] = -30274; vi[9] = 12540;
    for (int j = 0; j < NN; j++) begin
      tbl[j].n  = j;
      tbl[j].e  = ev[j];
      tbl[j].br = vr[ev[j]];
      tbl[j].bi = vi[ev[j]];
    end

    rst_n = 1'b0; in_valid = 1'b0; in_sop = 1'b0; in_r = '0; in_i = '0;
    model_reset();
    repeat (2) @(negedge clk);
    #1 chk_zero("reset_init");
    @(negedge clk);
    rst_n = 1'b1;

    tag = "pre_stream";
    for (int n = 0; n < 5; n++) sample(n == 0, 500 + n, 300 - n);
    do_reset("reset_mid_stream");

    tag = "first_frame";
    for (int j = 0; j < NN; j++) begin
      ov.vld = 1'b1; ov.sop = (tbl[j].n == 0); ov.eop = (tbl[j].n == NN - 1); ov.err = 1'b0;
      ov.ar = DW'(tbl[j].n); ov.ai = DW'(-tbl[j].n);
      ov.br = TW'(tbl[j].br); ov.bi = TW'(tbl[j].bi);
      step(1'b1, tbl[j].n == 0, tbl[j].n, -tbl[j].n, 1'b1, ov);
    end
    idle(2);

    tag = "gaps";
    for (int j = 0; j < 2 * NN; j++) begin
      if (j % 2 == 0) sample(j == 0, 1000 + j / 2, -(j / 2));
      else            step(1'b0, 1'b0, 4444, -4444, 1'b0, '0);
    end
    idle(2);

    tag = "back_to_back";
    err0 = errs_seen;
    for (int f = 0; f < 2; f++)
      for (int n = 0; n < NN; n++) sample(n == 0, 2000 + 16 * f + n, -n);
    idle(2);
    chk_int("b2b_frame_err_count", errs_seen - err0, 0);

    tag = "framing";
    err0 = errs_seen;
    for (int n = 0; n < 7; n++) sample(n == 0, 3000 + n, n);
    for (int n = 0; n < NN; n++) sample(n == 0, 3100 + n, -n);
    idle(2);
    sample(1'b0, 3333, 3333);
    idle(2);
    chk_int("framing_err_count", errs_seen - err0, 2);

    tag = "reset_mid_frame";
    for (int n = 0; n < 10; n++) sample(n == 0, 4000 + n, n);
    do_reset("reset_at_n9");
    tag = "after_reset";
    for (int n = 0; n < NN; n++) sample(n == 0, 5000 + n, -5000 - n);
    idle(3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
